// File: rtl/nios2e_pio_pkg.sv
// Shared definitions for the Nios II PIO input port family.
//   PIO_ADDR_*  : word addresses of the register map
//   EDGE_*      : encodings of the EDGE_TYPE parameter
//   pio_zext    : zero-extends a register of up to 32 bits onto the data bus
package nios2e_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Bits above the register width are masked off so they always read 0.
  function automatic logic [31:0] pio_zext(input logic [31:0] val, input int width);
    logic [31:0] keep;
    keep = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return val & keep;
  endfunction

endpackage

// File: rtl/nios2e_pio_debounce.sv
// One-bit debouncer for the PIO input port; only compiled in builds that
// define PIO_IN_DEBOUNCE_EN.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   din      : synchronised input bit
//   dout     : debounced bit, follows din only after DEB_CYC stable cycles
// The counter runs while din disagrees with dout and restarts whenever they
// agree again, so any excursion shorter than DEB_CYC cycles is discarded.
`ifdef PIO_IN_DEBOUNCE_EN
module nios2e_pio_debounce #(
  parameter int DEB_CYC = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (DEB_CYC < 1) ? 1 : $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEB_CYC - 1);

  logic [CNT_W-1:0] cnt_p0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p0 <= '0;
      dout   <= 1'b0;
    end else if (din == dout) begin
      cnt_p0 <= '0;
    end else if (cnt_p0 == CNT_TOP) begin
      dout   <= din;
      cnt_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/nios2e_pio_in_irq.sv
// Avalon-MM slave PIO input port with per-bit edge capture and a masked,
// level-sensitive interrupt.
//   clk, reset_n          : system clock, asynchronous active-low reset
//   address[1:0]          : 0 data (RO), 1 reserved, 2 irqmask (RW),
//                           3 edgecapture (RO, write-1-to-clear)
//   chipselect, write_n   : a write happens when chipselect && !write_n
//   writedata[31:0]       : write data
//   in_port[WIDTH-1:0]    : asynchronous external inputs
//   readdata[31:0]        : registered read data, 1 cycle after address
//   irq                   : registered |(edgecapture & irqmask)
// Build option: define PIO_IN_DEBOUNCE_EN to place a nios2e_pio_debounce
// per bit between the synchroniser and the edge detector.
module nios2e_pio_in_irq
  import nios2e_pio_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int EDGE_TYPE = 0,
  parameter int SYNC_STG  = 2,
  parameter int DEB_CYC   = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_p0 [SYNC_STG];
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] din_d;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic             wr_en;
  logic [31:0]      rd_mux;

  // Only the low WIDTH bits of writedata are meaningful, and DEB_CYC has no
  // effect unless debouncing is built in.
  logic unused_cfg;
  assign unused_cfg = ^{writedata, 32'(DEB_CYC)};

  function automatic logic [WIDTH-1:0] edge_sel(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] prev);
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (EDGE_TYPE)
      EDGE_FALL: return fall;
      EDGE_ANY:  return rise | fall;
      default:   return rise;
    endcase
  endfunction

  // ---- stage p0: synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STG; i++) sync_p0[i] <= '0;
    end else begin
      sync_p0[0] <= in_port;
      for (int i = 1; i < SYNC_STG; i++) sync_p0[i] <= sync_p0[i-1];
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  for (genvar g = 0; g < WIDTH; g++) begin : g_deb
    nios2e_pio_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sync_p0[SYNC_STG-1][g]),
      .dout    (din[g])
    );
  end
`else
  assign din = sync_p0[SYNC_STG-1];
`endif

  assign wr_en    = chipselect & ~write_n;
  assign edge_set = edge_sel(din, din_d);
  assign edge_clr = (wr_en && address == PIO_ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA: rd_mux = pio_zext(32'(din), WIDTH);
      PIO_ADDR_MASK: rd_mux = pio_zext(32'(irqmask), WIDTH);
      PIO_ADDR_EDGE: rd_mux = pio_zext(32'(edgecapture), WIDTH);
      default:       rd_mux = '0;
    endcase
  end

  // ---- stage p1: edge history, registers, read data and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_d       <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      din_d <= din;
      // A new edge overrides a same-cycle write-1-to-clear on that bit.
      edgecapture <= (edgecapture & ~edge_clr) | edge_set;
      if (wr_en && address == PIO_ADDR_MASK) irqmask <= writedata[WIDTH-1:0];
      readdata <= rd_mux;
      irq      <= |(edgecapture & irqmask);
    end
  end

endmodule
